// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game blocks.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StGo   = 3'd2,
    StShow = 3'd3,
    StFoul = 3'd4
  } state_e;

  localparam int unsigned MS_W    = 14;
  localparam int unsigned DELAY_W = 12;
  localparam int unsigned LFSR_W  = 16;

  // Taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with SEED on reset.
module game_lfsr
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Sequences one reaction round: random wait, GO, timing, then result or foul.
module reaction_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned       DELAY_MIN_MS = 1000,
  parameter logic [10:0]       DELAY_MASK   = 11'h7FF,
  parameter int unsigned       TIMEOUT_MS   = 9999,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_500Hz,
  input  logic            clk_2Hz,
  input  logic            start_pulse,
  input  logic            react_pulse,
  output logic            go_led,
  output logic            fail_led,
  output logic            busy,
  output logic            timeout,
  output logic [MS_W-1:0] result_ms,
  output logic            result_valid,
  output logic [2:0]      state
);

  logic [LFSR_W-1:0]  lfsr;
  logic               clk_500Hz_q;
  logic               tick;
  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d, delay_load;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d, result_q, result_d;
  logic               timeout_q, timeout_d, valid_q, valid_d;
  logic               go_q, busy_q;

  game_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Either edge of the 500 Hz level is one millisecond.
  assign tick       = clk_500Hz ^ clk_500Hz_q;
  assign delay_load = DELAY_W'(DELAY_MIN_MS) + DELAY_W'(lfsr[10:0] & DELAY_MASK);

  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    ms_cnt_d    = ms_cnt_q;
    result_d    = result_q;
    timeout_d   = timeout_q;
    valid_d     = 1'b0;
    case (state_q)
      StIdle, StShow, StFoul: begin
        if (start_pulse) begin
          delay_cnt_d = delay_load;
          timeout_d   = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (react_pulse) begin
          state_d = StFoul;
        end else if (tick) begin
          if (delay_cnt_q == DELAY_W'(1)) begin
            state_d  = StGo;
            ms_cnt_d = '0;
          end else begin
            delay_cnt_d = delay_cnt_q - DELAY_W'(1);
          end
        end
      end
      StGo: begin
        // A press wins over a same-cycle tick and reports the pre-tick count.
        if (react_pulse) begin
          result_d = ms_cnt_q;
          valid_d  = 1'b1;
          state_d  = StShow;
        end else if (tick) begin
          if (ms_cnt_q == MS_W'(TIMEOUT_MS - 1)) begin
            result_d  = MS_W'(TIMEOUT_MS);
            timeout_d = 1'b1;
            valid_d   = 1'b1;
            state_d   = StShow;
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_500Hz_q <= 1'b0;
      state_q     <= StIdle;
      delay_cnt_q <= '0;
      ms_cnt_q    <= '0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clk_500Hz_q <= clk_500Hz;
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
      ms_cnt_q    <= ms_cnt_d;
      result_q    <= result_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      go_q        <= (state_d == StGo);
      busy_q      <= (state_d == StWait) || (state_d == StGo);
    end
  end

  assign go_led       = go_q;
  assign busy         = busy_q;
  assign timeout      = timeout_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign state        = state_q;
  assign fail_led     = (state_q == StFoul) & clk_2Hz;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with a result scoreboard.
module tb_reaction_round_ctrl;

  typedef struct {
    int ms;
    int to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clk_500Hz, clk_2Hz, start_pulse, react_pulse;
  logic        go_led, fail_led, busy, timeout, result_valid;
  logic [13:0] result_ms;
  logic [2:0]  state;

  logic [15:0] model_lfsr;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          d;

  reaction_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .clk_500Hz    (clk_500Hz),
    .clk_2Hz      (clk_2Hz),
    .start_pulse  (start_pulse),
    .react_pulse  (react_pulse),
    .go_led       (go_led),
    .fail_led     (fail_led),
    .busy         (busy),
    .timeout      (timeout),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16 + x^14 + x^13 + x^11.
  always @(posedge clk or posedge rst) begin
    if (rst) model_lfsr <= 16'hACE1;
    else     model_lfsr <= {model_lfsr[14:0],
                            model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL sb_unexpected observed=%0d expected=none", result_ms);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result_ms", int'(result_ms), e.ms);
        chk("sb_timeout", int'(timeout), e.to);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      clk_500Hz = ~clk_500Hz;
      step();
    end
  endtask

  task automatic do_start(input string tag);
    d = 1000 + int'(model_lfsr[10:0]);
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    chk({tag, "_state_wait"}, int'(state), 1);
    chk({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic enter_go(input string tag);
    tick_n(d - 1);
    chk({tag, "_still_wait"}, int'(state), 1);
    tick_n(1);
    chk({tag, "_state_go"}, int'(state), 2);
    chk({tag, "_go_led"}, int'(go_led), 1);
  endtask

  initial begin
    rst = 1'b1;
    clk_500Hz = 1'b0;
    clk_2Hz = 1'b1;
    start_pulse = 1'b0;
    react_pulse = 1'b0;
    repeat (3) step();
    chk("rst_state", int'(state), 0);
    chk("rst_go_led", int'(go_led), 0);
    chk("rst_fail_led", int'(fail_led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_result_ms", int'(result_ms), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    rst = 1'b0;
    step();

    // Press start when the random part is zero so the wait is exactly 1000 ms.
    for (int g = 0; g < 20000 && model_lfsr[10:0] != 11'd0; g++) step();
    react_pulse = 1'b1;
    step();
    react_pulse = 1'b0;
    chk("idle_react_ignored", int'(state), 0);
    for (int g = 0; g < 20000 && model_lfsr[10:0] != 11'd0; g++) step();
    do_start("r1");
    enter_go("r1");

    tick_n(237);
    chk("r1_still_go", int'(state), 2);
    sb.push_back('{ms: 237, to: 0});
    react_pulse = 1'b1;
    step();
    react_pulse = 1'b0;
    chk("r1_state_show", int'(state), 3);
    chk("r1_valid", int'(result_valid), 1);
    chk("r1_result_ms", int'(result_ms), 237);
    chk("r1_timeout", int'(timeout), 0);
    chk("r1_busy", int'(busy), 0);
    step();
    chk("r1_valid_drop", int'(result_valid), 0);

    // Timeout round, started from SHOW.
    do_start("r2");
    enter_go("r2");
    tick_n(9998);
    chk("r2_still_go", int'(state), 2);
    sb.push_back('{ms: 9999, to: 1});
    tick_n(1);
    chk("r2_state_show", int'(state), 3);
    chk("r2_result_ms", int'(result_ms), 9999);
    chk("r2_timeout", int'(timeout), 1);
    chk("r2_valid", int'(result_valid), 1);

    // Foul at tick 500 of WAIT.
    do_start("r3");
    chk("r3_timeout_cleared", int'(timeout), 0);
    tick_n(500);
    react_pulse = 1'b1;
    step();
    react_pulse = 1'b0;
    chk("r3_state_foul", int'(state), 4);
    chk("r3_go_led", int'(go_led), 0);
    chk("r3_busy", int'(busy), 0);
    chk("r3_result_held", int'(result_ms), 9999);
    clk_2Hz = 1'b1;
    #1;
    chk("r3_fail_led_hi", int'(fail_led), 1);
    clk_2Hz = 1'b0;
    #1;
    chk("r3_fail_led_lo", int'(fail_led), 0);

    // React coincides with the final WAIT tick: foul wins.
    do_start("r4");
    tick_n(d - 1);
    react_pulse = 1'b1;
    clk_500Hz = ~clk_500Hz;
    step();
    react_pulse = 1'b0;
    chk("r4_state_foul", int'(state), 4);
    chk("r4_go_led", int'(go_led), 0);

    // Start ignored in WAIT and GO; react coincides with a tick at ms_cnt=41.
    do_start("r5");
    tick_n(10);
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    chk("r5_start_in_wait", int'(state), 1);
    tick_n(d - 11);
    chk("r5_still_wait", int'(state), 1);
    tick_n(1);
    chk("r5_state_go", int'(state), 2);
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
    chk("r5_start_in_go", int'(state), 2);
    tick_n(41);
    sb.push_back('{ms: 41, to: 0});
    react_pulse = 1'b1;
    clk_500Hz = ~clk_500Hz;
    step();
    react_pulse = 1'b0;
    chk("r5_state_show", int'(state), 3);
    chk("r5_result_ms", int'(result_ms), 41);

    // Asynchronous abort mid-GO.
    do_start("r6");
    enter_go("r6");
    tick_n(5);
    clk_2Hz = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("abort_state", int'(state), 0);
    chk("abort_go_led", int'(go_led), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_fail_led", int'(fail_led), 0);
    chk("abort_result_ms", int'(result_ms), 0);
    chk("abort_timeout", int'(timeout), 0);
    chk("abort_valid", int'(result_valid), 0);
    step();
    rst = 1'b0;
    step();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Round controller for the FPGA reaction game. It consumes the free-running divided clock levels produced by the clock divider and converts `clk_500Hz` edges into 1 ms ticks. It then sequences one round: pseudo-random wait, GO, reaction-time measurement, and then a result or foul. Its outputs drive the LEDs and the seven-segment display mux.

## Interface
- `DELAY_MIN_MS`, default 1000: fixed part of the pre-GO wait, in ms.
- `DELAY_MASK`, default 11'h7FF: mask applied to the LFSR to form the random part of the wait (0..2047 ms).
- `TIMEOUT_MS`, default 9999: saturating reaction-time limit, in ms.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.
- `clk`, in, 1: 100 MHz master clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `clk_500Hz`, in, 1: divider output level, same clock domain. Each edge (rise or fall) marks 1 ms.
- `clk_2Hz`, in, 1: divider output level, used for foul blinking.
- `start_pulse`, in, 1: debounced single-cycle start button.
- `react_pulse`, in, 1: debounced single-cycle reaction button.
- `go_led`, out, 1: lit while in GO.
- `fail_led`, out, 1: equals `clk_2Hz` while in FOUL, otherwise 0.
- `busy`, out, 1: high in WAIT and GO.
- `timeout`, out, 1: the last result was a timeout.
- `result_ms`, out, 14: last measured reaction time, in ms.
- `result_valid`, out, 1: one-cycle pulse on entry to SHOW.
- `state`, out, 3: current state encoding, for the display mux.

## Operation
- State encodings: IDLE=0, WAIT=1, GO=2, SHOW=3, FOUL=4.
- `tick` is `clk_500Hz XOR clk_500Hz_q`. The register `clk_500Hz_q` resets to 0.
- A 16-bit Fibonacci LFSR advances every `clk` cycle (taps 16,14,13,11) and resets to `LFSR_SEED`. The wait length therefore depends on when start is pressed.
- **IDLE:**
  - On `start_pulse`, load `delay_cnt = DELAY_MIN_MS + (lfsr[10:0] & DELAY_MASK)`, clear `timeout`, and go to WAIT.
  - `react_pulse` is ignored.
- **WAIT:**
  - `react_pulse` sends the FSM to FOUL. This has priority over a tick in the same cycle.
  - Otherwise, on a tick, if `delay_cnt == 1` go to GO and clear `ms_cnt`; else decrement `delay_cnt`.
  - `start_pulse` is ignored.
- **GO:**
  - `react_pulse` captures `result_ms <= ms_cnt` (the value before any same-cycle tick), pulses `result_valid`, and goes to SHOW.
  - Otherwise, on a tick, if `ms_cnt == TIMEOUT_MS - 1`, set `result_ms = TIMEOUT_MS` and `timeout = 1`, pulse `result_valid`, and go to SHOW. Else increment `ms_cnt`.
  - `start_pulse` is ignored.
- **SHOW:** `result_ms` and `timeout` are held. `start_pulse` starts a new round: identical to the IDLE start action, next state WAIT.
- **FOUL:** `result_ms` is unchanged. `start_pulse` behaves as in SHOW.
- Width rules:
  - `delay_cnt` is 12 bits. The maximum value is 3047 with default parameters; overflow is not allowed.
  - `ms_cnt` is 14 bits and never exceeds `TIMEOUT_MS`.

## Timing
- Reset values:
  - `state`=IDLE; `go_led`, `fail_led`, `busy`, `timeout`, `result_valid` = 0; `result_ms` = 0.
  - `delay_cnt` = 0, `ms_cnt` = 0, LFSR = `LFSR_SEED`.
- All outputs are registered, except `fail_led`, which is `(state==FOUL) & clk_2Hz`.
- Latencies:
  - `start_pulse` in cycle n gives `state`=WAIT and `busy`=1 in cycle n+1.
  - The N-th tick after WAIT entry, where N = loaded `delay_cnt`, gives GO in the following cycle.
  - `react_pulse` in GO at cycle n gives SHOW, `result_valid`=1 and `result_ms` updated in cycle n+1. `result_valid` is 0 in cycle n+2.
- The measured time is floor(ms elapsed since GO entry), with ±1 tick quantisation.
- `rst` asserted mid-round aborts immediately. Everything returns to reset values; there is no partial result.

## Structure
- Package `game_pkg`:
  - state localparams/enum (IDLE..FOUL)
  - `MS_W`=14
  - `DELAY_W`=12
  - LFSR tap constant
- Sub-module `game_lfsr`: 16-bit free-running LFSR with seed parameter and `rst`. It is reused later by other game blocks.
- The FSM, tick edge-detect and counters live in `reaction_round_ctrl`.

## Test plan
- **Reset and LFSR value:** hold `rst`, then release; pulse start while the LFSR is forced/known to give `lfsr[10:0]=0`, so `delay_cnt`=1000. Expected: after 1000 `clk_500Hz` edges, `state`=2 and `go_led`=1 one cycle later.
- **Normal reaction:** in GO, apply 237 ticks, then `react_pulse`. Expected: `result_ms`=237, `result_valid` high for exactly one cycle, `state`=3, `timeout`=0.
- **Foul:** `react_pulse` at tick 500 of WAIT. Expected: `state`=4, `go_led`=0, `fail_led` tracks `clk_2Hz`, `result_ms` unchanged.
- **Timeout:** in GO, apply 9999 ticks with no react. Expected: `result_ms`=9999, `timeout`=1, `state`=3.
- **Simultaneous events:**
  - `react_pulse` and a tick in the same cycle in GO at `ms_cnt`=41: expected `result_ms`=41.
  - Same coincidence in WAIT at `delay_cnt`=1: expected FOUL, not GO.
- **Ignore and abort:**
  - `start_pulse` during WAIT/GO has no effect.
  - `start` in SHOW gives WAIT with `timeout` cleared.
  - `rst` mid-GO makes all outputs 0 and `state`=0 immediately.
